// File: rtl/cpu_clk_gen_m_pkg.sv
// Shared definitions for the CPU phi1 clock generator: state encoding, default
// widths and the clock-control field positions in the map register.
package cpu_clk_gen_pkg;

  localparam int unsigned DEF_DIV_W       = 4;
  localparam int unsigned DEF_TO_W        = 6;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_WAIT = 2'd3
  } clk_state_e;

  // Clock-control fields of the map register feeding run/ratio/align inputs
  localparam int unsigned MAP_HI_DIV_LSB = 0;
  localparam int unsigned MAP_LO_DIV_LSB = 4;
  localparam int unsigned MAP_RUN_BIT    = 8;
  localparam int unsigned MAP_ALIGN_BIT  = 9;

endpackage

// File: rtl/cpu_clk_gen_m_sync_edge.sv
// Multi-stage synchroniser with a rising-edge detector on the synchronised
// level; usable for any asynchronous host strobe.
module sync_edge_m #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge = synchronised level now high, one cycle ago low
  assign rise_c = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/cpu_clk_gen_m.sv
// CPU phi1 clock generator: programmable high/low half-periods from the fast
// clock, run/stop control and optional alignment to the BBC phi0 rising edge.
module cpu_clk_gen_m
  import cpu_clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TO_W        = DEF_TO_W,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             bbc_ck8,
  input  logic             reset,
  input  logic             run_ip,
  input  logic [DIV_W-1:0] hi_div_ip,
  input  logic [DIV_W-1:0] lo_div_ip,
  input  logic             ls_align_ip,
  input  logic             bbc_ck2_phi0_ip,
  output logic             ck_op,
  output logic             rise_op,
  output logic             fall_op,
  output logic             stopped_op,
  output logic             aligned_op,
  output logic             timeout_op,
  output logic [CNT_W-1:0] period_cnt_op
);

  clk_state_e       state_q, state_d;
  logic [DIV_W-1:0] hi_q, hi_d;
  logic [DIV_W-1:0] lo_q, lo_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             ck_d, rise_d, fall_d, stopped_d, aligned_d, timeout_d;
  logic [CNT_W-1:0] period_d;
  logic             go_hi;
  logic             phi0_rise_c;

  sync_edge_m #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_phi0_sync (
    .clk    (bbc_ck8),
    .reset  (reset),
    .din    (bbc_ck2_phi0_ip),
    .rise_c (phi0_rise_c)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    aligned_d = 1'b0;
    timeout_d = timeout_op;
    period_d  = period_cnt_op;
    go_hi     = 1'b0;

    case (state_q)
      ST_STOP: begin
        if (run_ip) go_hi = 1'b1;
      end
      ST_HI: begin
        if (cnt_q == '0) begin
          state_d = ST_LO;
          cnt_d   = lo_q;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_LO: begin
        if (cnt_q == '0) begin
          period_d = period_cnt_op + CNT_W'(1);
          if (!run_ip) begin
            state_d = ST_STOP;
          end else if (ls_align_ip) begin
            state_d = ST_WAIT;
            to_d    = '0;
          end else begin
            go_hi = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_WAIT: begin
        // Stop beats edge, edge beats timeout
        if (!run_ip) begin
          state_d = ST_STOP;
        end else if (phi0_rise_c) begin
          go_hi     = 1'b1;
          aligned_d = 1'b1;
        end else if (&to_q) begin
          go_hi     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = ST_STOP;
    endcase

    // Period start: ratios are sampled only here
    if (go_hi) begin
      state_d = ST_HI;
      hi_d    = hi_div_ip;
      lo_d    = lo_div_ip;
      cnt_d   = hi_div_ip;
      rise_d  = 1'b1;
    end

    ck_d      = (state_d == ST_HI);
    stopped_d = (state_d == ST_STOP);
  end

  always_ff @(posedge bbc_ck8) begin
    if (reset) begin
      state_q       <= ST_STOP;
      hi_q          <= '0;
      lo_q          <= '0;
      cnt_q         <= '0;
      to_q          <= '0;
      ck_op         <= 1'b0;
      rise_op       <= 1'b0;
      fall_op       <= 1'b0;
      stopped_op    <= 1'b1;
      aligned_op    <= 1'b0;
      timeout_op    <= 1'b0;
      period_cnt_op <= '0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      cnt_q         <= cnt_d;
      to_q          <= to_d;
      ck_op         <= ck_d;
      rise_op       <= rise_d;
      fall_op       <= fall_d;
      stopped_op    <= stopped_d;
      aligned_op    <= aligned_d;
      timeout_op    <= timeout_d;
      period_cnt_op <= period_d;
    end
  end

endmodule

// File: tb/tb_cpu_clk_gen_m.sv
// Directed bench for cpu_clk_gen_m: ratios, run/stop, phi0 alignment,
// alignment timeout and mid-period reset, with hand-computed expectations.
module tb_cpu_clk_gen_m;

  localparam int unsigned DIV_W       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TO_W        = 6;
  localparam int unsigned CNT_W       = 16;

  logic             bbc_ck8 = 1'b0;
  logic             reset;
  logic             run_ip;
  logic [DIV_W-1:0] hi_div_ip;
  logic [DIV_W-1:0] lo_div_ip;
  logic             ls_align_ip;
  logic             bbc_ck2_phi0_ip;
  logic             ck_op;
  logic             rise_op;
  logic             fall_op;
  logic             stopped_op;
  logic             aligned_op;
  logic             timeout_op;
  logic [CNT_W-1:0] period_cnt_op;

  int n_vec = 0;
  int n_err = 0;

  cpu_clk_gen_m #(
    .DIV_W       (DIV_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TO_W        (TO_W),
    .CNT_W       (CNT_W)
  ) dut (
    .bbc_ck8         (bbc_ck8),
    .reset           (reset),
    .run_ip          (run_ip),
    .hi_div_ip       (hi_div_ip),
    .lo_div_ip       (lo_div_ip),
    .ls_align_ip     (ls_align_ip),
    .bbc_ck2_phi0_ip (bbc_ck2_phi0_ip),
    .ck_op           (ck_op),
    .rise_op         (rise_op),
    .fall_op         (fall_op),
    .stopped_op      (stopped_op),
    .aligned_op      (aligned_op),
    .timeout_op      (timeout_op),
    .period_cnt_op   (period_cnt_op)
  );

  always #5 bbc_ck8 = ~bbc_ck8;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One fast-clock edge; outputs are settled on return and inputs may change
  task automatic step();
    @(posedge bbc_ck8);
    #1;
  endtask

  task automatic wait_rise(input string tag, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (rise_op) seen = 1'b1;
    end
    chk_vec(tag, 32'(seen), 32'd1);
  endtask

  // Called just after a rise_op; measures high and low lengths up to the next rise_op
  task automatic measure(input string tag, input int exp_hi, input int exp_lo);
    int hi_len = 1;
    int lo_len = 1;
    step();
    while (ck_op && hi_len < 300) begin
      hi_len++;
      step();
    end
    step();
    while (!rise_op && lo_len < 300) begin
      lo_len++;
      step();
    end
    chk_vec({tag, "_hi"}, 32'(hi_len), 32'(exp_hi));
    chk_vec({tag, "_lo"}, 32'(lo_len), 32'(exp_lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int quiet;
    reset = 1'b1; run_ip = 1'b0; hi_div_ip = '0; lo_div_ip = '0;
    ls_align_ip = 1'b0; bbc_ck2_phi0_ip = 1'b0;
    step(); step();
    chk_vec("rst_ck",      32'(ck_op),         32'd0);
    chk_vec("rst_rise",    32'(rise_op),       32'd0);
    chk_vec("rst_fall",    32'(fall_op),       32'd0);
    chk_vec("rst_stopped", 32'(stopped_op),    32'd1);
    chk_vec("rst_aligned", 32'(aligned_op),    32'd0);
    chk_vec("rst_timeout", 32'(timeout_op),    32'd0);
    chk_vec("rst_period",  32'(period_cnt_op), 32'd0);

    reset = 1'b0;
    step();
    chk_vec("idle_stopped", 32'(stopped_op), 32'd1);
    chk_vec("idle_ck",      32'(ck_op),      32'd0);

    // Divide-by-2: high on odd edges after run, one period completes every 2 edges
    run_ip = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      step();
      chk_vec("div2_ck", 32'(ck_op), 32'(i % 2));
      if (i == 1) chk_vec("div2_first_rise", 32'(rise_op), 32'd1);
      if (i == 2) chk_vec("div2_first_fall", 32'(fall_op), 32'd1);
    end
    chk_vec("div2_period", 32'(period_cnt_op), 32'd10);

    // 3/5 shape, then a mid-high change only affects the following period
    hi_div_ip = 4'd2; lo_div_ip = 4'd4;
    wait_rise("rise_2_4", 8);
    chk_vec("period_11", 32'(period_cnt_op), 32'd11);
    measure("shape_2_4a", 3, 5);
    hi_div_ip = 4'd1; lo_div_ip = 4'd1;
    measure("shape_2_4b", 3, 5);
    measure("shape_1_1", 2, 2);
    chk_vec("period_14", 32'(period_cnt_op), 32'd14);

    // Run dropped in the first high cycle: both halves finish, then STOP
    run_ip = 1'b0;
    step(); chk_vec("stop_hi_done", 32'(ck_op), 32'd1);
    step(); chk_vec("stop_fall",    32'(fall_op), 32'd1);
    step();
    chk_vec("stop_lo_ck",  32'(ck_op),      32'd0);
    chk_vec("stop_lo_run", 32'(stopped_op), 32'd0);
    step();
    chk_vec("stop_entered", 32'(stopped_op),    32'd1);
    chk_vec("stop_ck",      32'(ck_op),         32'd0);
    chk_vec("stop_period",  32'(period_cnt_op), 32'd15);
    step();
    chk_vec("stop_hold", 32'(stopped_op), 32'd1);
    run_ip = 1'b1;
    step();
    chk_vec("restart_rise",    32'(rise_op),    32'd1);
    chk_vec("restart_stopped", 32'(stopped_op), 32'd0);

    // Alignment: phi0 rises 7 cycles into WAIT, HI follows SYNC_STAGES+1 edges later
    ls_align_ip = 1'b1;
    repeat (4) step();
    chk_vec("wait_ck",      32'(ck_op),         32'd0);
    chk_vec("wait_stopped", 32'(stopped_op),    32'd0);
    chk_vec("wait_period",  32'(period_cnt_op), 32'd16);
    quiet = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (!ck_op && !rise_op) quiet++;
    end
    chk_vec("wait_quiet", 32'(quiet), 32'd7);
    bbc_ck2_phi0_ip = 1'b1;
    step(); chk_vec("align_lat1", 32'(rise_op), 32'd0);
    step(); chk_vec("align_lat2", 32'(rise_op), 32'd0);
    step();
    chk_vec("align_rise",    32'(rise_op),    32'd1);
    chk_vec("align_pulse",   32'(aligned_op), 32'd1);
    chk_vec("align_timeout", 32'(timeout_op), 32'd0);

    // Timeout: phi0 held low, HI after 64 WAIT cycles
    bbc_ck2_phi0_ip = 1'b0;
    repeat (4) step();
    chk_vec("to_wait_ck",     32'(ck_op),         32'd0);
    chk_vec("to_wait_period", 32'(period_cnt_op), 32'd17);
    quiet = 0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (!ck_op && !rise_op) quiet++;
    end
    chk_vec("to_quiet", 32'(quiet), 32'd63);
    step();
    chk_vec("to_rise",    32'(rise_op),    32'd1);
    chk_vec("to_sticky",  32'(timeout_op), 32'd1);
    chk_vec("to_aligned", 32'(aligned_op), 32'd0);

    // All-ones ratio: 16 high, 16 low
    ls_align_ip = 1'b0;
    hi_div_ip = 4'hF; lo_div_ip = 4'hF;
    wait_rise("rise_max", 8);
    measure("shape_max", 16, 16);
    chk_vec("to_still_set", 32'(timeout_op), 32'd1);

    // Reset in the middle of a high half
    repeat (3) step();
    chk_vec("pre_reset_ck", 32'(ck_op), 32'd1);
    reset = 1'b1;
    step();
    chk_vec("mid_rst_ck",      32'(ck_op),         32'd0);
    chk_vec("mid_rst_stopped", 32'(stopped_op),    32'd1);
    chk_vec("mid_rst_period",  32'(period_cnt_op), 32'd0);
    chk_vec("mid_rst_timeout", 32'(timeout_op),    32'd0);
    chk_vec("mid_rst_rise",    32'(rise_op),       32'd0);

    // run dropped while in WAIT overrides a pending phi0 edge
    reset = 1'b0; hi_div_ip = '0; lo_div_ip = '0; ls_align_ip = 1'b1;
    step(); chk_vec("ws_rise", 32'(rise_op), 32'd1);
    step(); chk_vec("ws_fall", 32'(fall_op), 32'd1);
    step();
    chk_vec("ws_wait_stopped", 32'(stopped_op),    32'd0);
    chk_vec("ws_wait_period",  32'(period_cnt_op), 32'd1);
    run_ip = 1'b0; bbc_ck2_phi0_ip = 1'b1;
    step();
    chk_vec("ws_stop", 32'(stopped_op), 32'd1);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!ck_op && !rise_op && !aligned_op && stopped_op) quiet++;
    end
    chk_vec("ws_hold", 32'(quiet), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
